// File: rtl/gf180mcu_ef_io__gpio_pkg.sv
// Shared constants for the GPIO pad control slice: configuration bit map,
// direction FSM encoding and the pull-resolution helper.
package gf180mcu_ef_io__gpio_pkg;

    localparam int CFG_W = 9;

    localparam int CFG_DOUT   = 0;
    localparam int CFG_OE_REQ = 1;
    localparam int CFG_IE     = 2;
    localparam int CFG_PU     = 3;
    localparam int CFG_PD     = 4;
    localparam int CFG_CS     = 5;
    localparam int CFG_SL     = 6;
    localparam int CFG_PDRV0  = 7;
    localparam int CFG_PDRV1  = 8;

    typedef enum logic [1:0] {
        ST_IN       = 2'd0,
        ST_TURN_ON  = 2'd1,
        ST_OUT      = 2'd2,
        ST_TURN_OFF = 2'd3
    } dir_state_e;

    // Returns {pu, pd}; pull-down wins so the pad never sees both pulls on.
    function automatic logic [1:0] pull_sel(input logic pu, input logic pd);
        return {pu & ~pd, pd};
    endfunction

endpackage

// File: rtl/gf180mcu_ef_io__gpio_if.sv
// Core-side configuration/status bundle of the GPIO pad controller.
interface gf180mcu_ef_io__gpio_if;
    import gf180mcu_ef_io__gpio_pkg::*;

    logic             cfg_we;
    logic [CFG_W-1:0] cfg_wdata;
    logic [CFG_W-1:0] cfg_q;
    logic             irq_clr;
    logic [1:0]       irq_en;
    logic             din;
    logic             irq;
    logic             busy;

    modport master (
        output cfg_we, cfg_wdata, irq_clr, irq_en,
        input  cfg_q, din, irq, busy
    );

    modport slave (
        input  cfg_we, cfg_wdata, irq_clr, irq_en,
        output cfg_q, din, irq, busy
    );

endinterface

// File: rtl/gf180mcu_ef_io__gpio_infilt.sv
// Pad input conditioning: 2-flop synchronizer, debounce filter and
// single-cycle rise/fall pulses on the filtered value.
module gf180mcu_ef_io__gpio_infilt
    import gf180mcu_ef_io__gpio_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic pad_y_i,
    input  logic ie_i,
    output logic din_o,
    output logic rise_o,
    output logic fall_o
);

    logic       sync1_q, sync2_q;
    logic       din_q, rise_q, fall_q;
    logic [7:0] cnt_q;
    logic       sync_d;
    logic [8:0] cnt_inc;

    // With the input buffer off, feed back the held value so no edge can appear.
    assign sync_d  = ie_i ? pad_y_i : din_q;
    assign cnt_inc = {1'b0, cnt_q} + 9'd1;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            din_q   <= 1'b0;
            cnt_q   <= '0;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
        end else begin
            sync1_q <= sync_d;
            sync2_q <= sync1_q;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
            if (sync2_q == din_q) begin
                cnt_q <= '0;
            end else if (cnt_inc >= 9'(DEBOUNCE_CYCLES)) begin
                din_q  <= sync2_q;
                cnt_q  <= '0;
                rise_q <= sync2_q;
                fall_q <= ~sync2_q;
            end else begin
                cnt_q <= cnt_inc[7:0];
            end
        end
    end

    assign din_o  = din_q;
    assign rise_o = rise_q;
    assign fall_o = fall_q;

endmodule

// File: rtl/gf180mcu_ef_io__gpio_ctrl.sv
// Control stage in front of one bidirectional pad: registered pad pins,
// OE turnaround sequencing and a sticky edge interrupt on the filtered input.
module gf180mcu_ef_io__gpio_ctrl
    import gf180mcu_ef_io__gpio_pkg::*;
#(
    parameter int               TURN_CYCLES     = 2,
    parameter int               DEBOUNCE_CYCLES = 4,
    parameter logic [CFG_W-1:0] CFG_RESET       = 9'h010
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    gf180mcu_ef_io__gpio_if.slave      bus,
    output logic                       pad_cs_o,
    output logic                       pad_sl_o,
    output logic                       pad_ie_o,
    output logic                       pad_oe_o,
    output logic                       pad_pu_o,
    output logic                       pad_pd_o,
    output logic                       pad_a_o,
    output logic                       pad_pdrv0_o,
    output logic                       pad_pdrv1_o,
    input  logic                       pad_y_i
);

    localparam logic [3:0] TURN_LD = 4'(TURN_CYCLES);
    localparam logic [1:0] PULL_RST = {CFG_RESET[CFG_PU] & ~CFG_RESET[CFG_PD], CFG_RESET[CFG_PD]};

    logic [CFG_W-1:0] cfg_q;
    dir_state_e       state_q, state_d;
    logic [3:0]       tcnt_q, tcnt_d;
    logic             pad_oe_q, pad_ie_q, pad_a_q, busy_q, irq_q;
    logic             pad_cs_q, pad_sl_q, pad_pdrv0_q, pad_pdrv1_q;
    logic [1:0]       pull_q;
    logic             oe_req, din, rise, fall, irq_set;

    assign oe_req  = cfg_q[CFG_OE_REQ];
    assign irq_set = (rise & bus.irq_en[0]) | (fall & bus.irq_en[1]);

    always_comb begin
        state_d = state_q;
        tcnt_d  = tcnt_q;
        unique case (state_q)
            ST_IN: begin
                if (oe_req) begin
                    state_d = ST_TURN_ON;
                    tcnt_d  = TURN_LD;
                end
            end
            ST_TURN_ON: begin
                if (!oe_req) begin
                    state_d = ST_IN;
                    tcnt_d  = '0;
                end else if (tcnt_q <= 4'd1) begin
                    state_d = ST_OUT;
                    tcnt_d  = '0;
                end else begin
                    tcnt_d = tcnt_q - 4'd1;
                end
            end
            ST_OUT: begin
                if (!oe_req) begin
                    state_d = ST_TURN_OFF;
                    tcnt_d  = TURN_LD;
                end
            end
            ST_TURN_OFF: begin
                if (oe_req) begin
                    state_d = ST_TURN_ON;
                    tcnt_d  = TURN_LD;
                end else if (tcnt_q <= 4'd1) begin
                    state_d = ST_IN;
                    tcnt_d  = '0;
                end else begin
                    tcnt_d = tcnt_q - 4'd1;
                end
            end
            default: begin
                state_d = ST_IN;
                tcnt_d  = '0;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cfg_q       <= CFG_RESET;
            state_q     <= ST_IN;
            tcnt_q      <= '0;
            pad_oe_q    <= 1'b0;
            pad_ie_q    <= CFG_RESET[CFG_IE];
            pad_a_q     <= 1'b0;
            busy_q      <= 1'b0;
            pad_cs_q    <= CFG_RESET[CFG_CS];
            pad_sl_q    <= CFG_RESET[CFG_SL];
            pad_pdrv0_q <= CFG_RESET[CFG_PDRV0];
            pad_pdrv1_q <= CFG_RESET[CFG_PDRV1];
            pull_q      <= PULL_RST;
            irq_q       <= 1'b0;
        end else begin
            if (bus.cfg_we) begin
                cfg_q <= bus.cfg_wdata;
            end
            state_q  <= state_d;
            tcnt_q   <= tcnt_d;
            // OE rises one cycle after OUT is entered but drops on the very edge OUT is left.
            pad_oe_q <= (state_q == ST_OUT) && (state_d == ST_OUT);
            pad_ie_q <= cfg_q[CFG_IE] && (state_d != ST_TURN_OFF);
            busy_q   <= (state_d == ST_TURN_ON) || (state_d == ST_TURN_OFF);
            pad_a_q     <= cfg_q[CFG_DOUT];
            pad_cs_q    <= cfg_q[CFG_CS];
            pad_sl_q    <= cfg_q[CFG_SL];
            pad_pdrv0_q <= cfg_q[CFG_PDRV0];
            pad_pdrv1_q <= cfg_q[CFG_PDRV1];
            pull_q      <= pull_sel(cfg_q[CFG_PU], cfg_q[CFG_PD]);
            irq_q       <= irq_set | (irq_q & ~bus.irq_clr);
        end
    end

    gf180mcu_ef_io__gpio_infilt #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_infilt (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .pad_y_i(pad_y_i),
        .ie_i   (pad_ie_q),
        .din_o  (din),
        .rise_o (rise),
        .fall_o (fall)
    );

    assign bus.cfg_q = cfg_q;
    assign bus.din   = din;
    assign bus.irq   = irq_q;
    assign bus.busy  = busy_q;

    assign pad_cs_o    = pad_cs_q;
    assign pad_sl_o    = pad_sl_q;
    assign pad_ie_o    = pad_ie_q;
    assign pad_oe_o    = pad_oe_q;
    assign pad_pu_o    = pull_q[1];
    assign pad_pd_o    = pull_q[0];
    assign pad_a_o     = pad_a_q;
    assign pad_pdrv0_o = pad_pdrv0_q;
    assign pad_pdrv1_o = pad_pdrv1_q;

endmodule
